// File: rtl/vc_rand_num_arb.sv
// Shared Tausworthe random-number server: round-robin grants, one-entry
// response buffer, run-time reseed.
`timescale 1ns/1ps
module vc_rand_num_arb #(
  parameter int          p_num_reqs  = 4,
  parameter int          p_out_nbits = 8,
  parameter logic [31:0] p_seed      = 32'hdeadbeef
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [p_num_reqs-1:0]  req_val,
  output logic [p_num_reqs-1:0]  req_rdy,
  output logic [p_num_reqs-1:0]  resp_val,
  input  logic [p_num_reqs-1:0]  resp_rdy,
  output logic [p_out_nbits-1:0] resp_msg,
  input  logic                   cfg_seed_val,
  input  logic [31:0]            cfg_seed
);

  localparam int PW = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e                 state_q;
  logic [PW-1:0]          owner_q;
  logic [PW-1:0]          ptr_q;
  logic [31:0]            rand_q;

  logic [31:0]            tw_t;
  logic [31:0]            rand_nxt;
  logic [31:0]            seed_ld;
  logic [p_out_nbits-1:0] fold;
  logic                   drain;
  logic                   free;
  logic                   gnt_found;
  logic [PW-1:0]          gnt_idx;
  logic [PW-1:0]          ptr_nxt;
  logic                   fire;
  int                     idx;

  assign tw_t     = (rand_q >> 17) ^ rand_q;
  assign rand_nxt = (tw_t << 15) ^ tw_t;
  assign seed_ld  = (cfg_seed == 32'd0) ? p_seed : cfg_seed;

  always_comb begin
    fold = rand_q[p_out_nbits-1:0];
    for (int i = 2*p_out_nbits-1; i < 31; i += p_out_nbits)
      fold = fold ^ rand_q[i -: p_out_nbits];
  end

  // Only the addressed requester's ready can drain the buffer.
  assign drain = (state_q == FULL) && resp_rdy[owner_q];
  assign free  = (state_q == EMPTY) || drain;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < p_num_reqs; i++) begin
      idx = (int'(ptr_q) + i) % p_num_reqs;
      if (!gnt_found && req_val[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
  end

  assign fire = free && !cfg_seed_val && gnt_found;

  always_comb begin
    req_rdy = '0;
    if (fire)
      req_rdy[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = (gnt_idx == PW'(p_num_reqs-1))
                 ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      owner_q  <= '0;
      ptr_q    <= '0;
      rand_q   <= p_seed;
      resp_val <= '0;
      resp_msg <= '0;
    end else begin
      if (cfg_seed_val)
        rand_q <= seed_ld;
      else if (fire)
        rand_q <= rand_nxt;
      if (fire)
        ptr_q <= ptr_nxt;
      unique case (1'b1)
        fire: begin
          state_q  <= FULL;
          owner_q  <= gnt_idx;
          resp_val <= req_rdy;
          resp_msg <= fold;
        end
        (drain && !fire): begin
          state_q  <= EMPTY;
          resp_val <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_rand_num_arb.sv
// Directed bench for vc_rand_num_arb with 4 requesters, 8-bit responses.
`timescale 1ns/1ps
module tb_vc_rand_num_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_val;
  logic [3:0]  req_rdy;
  logic [3:0]  resp_val;
  logic [3:0]  resp_rdy;
  logic [7:0]  resp_msg;
  logic        cfg_seed_val;
  logic [31:0] cfg_seed;

  int n_cmp;
  int n_fail;
  logic [31:0] m_rand;
  logic [7:0]  m_msg;

  vc_rand_num_arb #(
    .p_num_reqs  (4),
    .p_out_nbits (8),
    .p_seed      (32'hdeadbeef)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_msg     (resp_msg),
    .cfg_seed_val (cfg_seed_val),
    .cfg_seed     (cfg_seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tw_step(input logic [31:0] r);
    logic [31:0] t;
    t = (r >> 17) ^ r;
    return (t << 15) ^ t;
  endfunction

  function automatic logic [7:0] fold8(input logic [31:0] r);
    return r[7:0] ^ r[15:8] ^ r[23:16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    req_val      = '0;
    resp_rdy     = '0;
    cfg_seed_val = 1'b0;
    cfg_seed     = '0;
    step();
    step();
    reset_n = 1'b1;
    m_rand  = 32'hdeadbeef;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (resp_val !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_resp_val: got %b want 0000", resp_val);
    end
    n_cmp++;
    if (resp_msg !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_resp_msg: got %h want 00", resp_msg);
    end
    n_cmp++;
    if (req_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_req_rdy: got %b want 0000", req_rdy);
    end
    req_val  = 4'b0001;
    resp_rdy = 4'b0001;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant: got %b want 0001", req_rdy);
    end
    step();
    n_cmp++;
    if (resp_val !== 4'b0001 || resp_msg !== 8'hfc) begin
      n_fail++;
      $display("FAIL first_value: got %b/%h want 0001/fc",
               resp_val, resp_msg);
    end
    n_cmp++;
    if (req_rdy !== 4'b0001) begin
      n_fail++;
      $display("FAIL refill_grant: got %b want 0001", req_rdy);
    end
    step();
    n_cmp++;
    if (resp_msg !== 8'h99) begin
      n_fail++;
      $display("FAIL second_value: got %h want 99", resp_msg);
    end
    req_val = '0;
    step();
    n_cmp++;
    if (resp_val !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_drain: got %b want 0000", resp_val);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    do_reset();
    req_val  = 4'b1111;
    resp_rdy = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = 4'(1 << (i % 4));
      #1;
      n_cmp++;
      if (req_rdy !== g) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b want %b", i, req_rdy, g);
      end
      m_msg  = fold8(m_rand);
      m_rand = tw_step(m_rand);
      step();
      n_cmp++;
      if (resp_val !== g || resp_msg !== m_msg) begin
        n_fail++;
        $display("FAIL rr_resp%0d: got %b/%h want %b/%h",
                 i, resp_val, resp_msg, g, m_msg);
      end
    end
    req_val = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_val  = 4'b0100;
    resp_rdy = 4'b0000;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_grant2: got %b want 0100", req_rdy);
    end
    step();
    req_val  = 4'b1111;
    resp_rdy = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (req_rdy !== 4'b0000 || resp_val !== 4'b0100 ||
          resp_msg !== 8'hfc) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %b/%b/%h want 0000/0100/fc",
                 c, req_rdy, resp_val, resp_msg);
      end
      step();
    end
    resp_rdy = 4'b0100;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_refill_grant: got %b want 1000", req_rdy);
    end
    step();
    n_cmp++;
    if (resp_val !== 4'b1000 || resp_msg !== 8'h99) begin
      n_fail++;
      $display("FAIL bp_next: got %b/%h want 1000/99",
               resp_val, resp_msg);
    end
    req_val  = '0;
    resp_rdy = 4'b1111;
    step();
  endtask

  task automatic test_zero_seed();
    do_reset();
    req_val  = 4'b0001;
    resp_rdy = 4'b0001;
    step();
    cfg_seed_val = 1'b1;
    cfg_seed     = 32'h0;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL zs_no_grant: got %b want 0000", req_rdy);
    end
    step();
    cfg_seed_val = 1'b0;
    n_cmp++;
    if (resp_val !== 4'b0000) begin
      n_fail++;
      $display("FAIL zs_drained: got %b want 0000", resp_val);
    end
    step();
    n_cmp++;
    if (resp_val !== 4'b0001 || resp_msg !== 8'hfc) begin
      n_fail++;
      $display("FAIL zs_value: got %b/%h want 0001/fc",
               resp_val, resp_msg);
    end
    req_val = '0;
    step();
  endtask

  task automatic test_reseed_drain();
    do_reset();
    req_val  = 4'b0010;
    resp_rdy = 4'b0000;
    step();
    req_val      = 4'b0000;
    resp_rdy     = 4'b0010;
    cfg_seed_val = 1'b1;
    cfg_seed     = 32'hdeadbeef;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL rs_no_grant: got %b want 0000", req_rdy);
    end
    step();
    cfg_seed_val = 1'b0;
    n_cmp++;
    if (resp_val !== 4'b0000) begin
      n_fail++;
      $display("FAIL rs_drained: got %b want 0000", resp_val);
    end
    req_val = 4'b0010;
    step();
    n_cmp++;
    if (resp_val !== 4'b0010 || resp_msg !== 8'hfc) begin
      n_fail++;
      $display("FAIL rs_value: got %b/%h want 0010/fc",
               resp_val, resp_msg);
    end
    req_val = '0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_val  = 4'b0001;
    resp_rdy = 4'b0000;
    step();
    req_val = 4'b0000;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (resp_val !== 4'b0000) begin
      n_fail++;
      $display("FAIL ar_immediate: got %b want 0000", resp_val);
    end
    step();
    reset_n  = 1'b1;
    req_val  = 4'b1111;
    resp_rdy = 4'b1111;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0001) begin
      n_fail++;
      $display("FAIL ar_ptr0: got %b want 0001", req_rdy);
    end
    step();
    n_cmp++;
    if (resp_val !== 4'b0001 || resp_msg !== 8'hfc) begin
      n_fail++;
      $display("FAIL ar_value: got %b/%h want 0001/fc",
               resp_val, resp_msg);
    end
    req_val = '0;
    step();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_zero_seed();
    test_reseed_drain();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_rand_num_arb.md
# vc_rand_num_arb

Shared pseudo-random number server for test sources, sinks and stall injectors. It owns one 32-bit Tausworthe generator state and hands out folded random words to up to `p_num_reqs` requesters, using a round-robin arbiter and per-requester val/rdy handshakes. Each response sits in a one-entry output buffer, so a requester gets a distinct value per fire. A configuration port reseeds the generator at run time.

## Interface
- `p_num_reqs`, 4: number of requesters, 2..16.
- `p_out_nbits`, 8: response width, 1..16.
- `p_seed`, 32'hdeadbeef: reset seed, also used as the substitute for a zero seed load.

- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_val`  in  p_num_reqs  per-requester request valid.
- `req_rdy`  out  p_num_reqs  per-requester grant; at most one bit set.
- `resp_val`  out  p_num_reqs  one-hot response valid, addressed to the granted requester.
- `resp_rdy`  in  p_num_reqs  per-requester response ready.
- `resp_msg`  out  p_out_nbits  random value, shared by all requesters.
- `cfg_seed_val`  in  1  load `cfg_seed` this cycle.
- `cfg_seed`  in  32  new generator state.

## Operation
- **State:** `rand` (32 bits), `ptr` (round-robin pointer, clog2 of `p_num_reqs` bits), `resp_val` register, `resp_msg` register.
- **Reset values** (asynchronous, while `reset_n`=0): `rand`=`p_seed`, `ptr`=0, `resp_val`=0, `resp_msg`=0.
- **Generator step:**
  - t = (rand >> 17) ^ rand.
  - rand_next = (t << 15) ^ t, truncated to 32 bits.
- **Fold** (combinational from current `rand`):
  - Start with f = rand[p_out_nbits-1:0].
  - For i = 2*p_out_nbits-1, stepping by p_out_nbits, while i < 31: f ^= rand[i -: p_out_nbits].
- **Buffer FSM:**
  - EMPTY: `resp_val`=0.
  - FULL(k): `resp_val`=onehot(k).
  - FULL(k) → EMPTY on resp_rdy[k] when no new grant is made that cycle.
  - EMPTY or draining → FULL(j) on a request fire.
- **Buffer free condition:** free = EMPTY, or FULL(k) with resp_rdy[k]=1.
- **Grant:**
  - If free and !cfg_seed_val, req_rdy[j]=1 for the first j with req_val[j]=1, scanning from `ptr` upward with wrap.
  - Otherwise req_rdy=0.
  - req_rdy has a combinational dependence on `resp_rdy` and `req_val`.
- **On fire of j:**
  - `resp_msg` ← f.
  - `resp_val` ← onehot(j).
  - `rand` ← rand_next.
  - `ptr` ← (j+1) mod p_num_reqs.
- **Seed load:**
  - `rand` ← cfg_seed, or `p_seed` if cfg_seed==0.
  - The load suppresses all grants that cycle.
  - A pending response is unaffected and may still drain that cycle.
- The generator advances only on a fire, never when idle.
- `resp_rdy` bits of non-addressed requesters are ignored.

## Timing
- **Latency:** a fire in cycle n gives `resp_val`/`resp_msg` valid from cycle n+1. The value is the fold of `rand` as it was in cycle n.
- **Throughput:** one response per cycle when the addressed requester holds resp_rdy=1. In the drain-and-refill cycle, a new grant is allowed.
- `resp_msg` and `resp_val` stay stable while FULL and not drained.
- **Fairness:** a requester holding req_val=1 is granted within p_num_reqs fires.
- **Reset mid-operation:** the pending response is discarded immediately, and the sequence restarts from `p_seed`.
- **Simultaneous events:**
  - cfg_seed_val with drain → drain happens, seed loads, no grant.
  - cfg_seed_val with no request → seed loads.

## Test plan
- **Reset and first values:** reset, then req_val[0]=1 and resp_rdy[0]=1 held with 8-bit defaults. Required: resp_msg 0xfc in cycle 1, then 0x99. Internal rand sequence 0xdeadbeef → 0x367151b9.
- **Round robin:** req_val=4'b1111 held, all resp_rdy=1. Required: grants 0,1,2,3,0 on consecutive cycles, and resp_val one-hot follows one cycle later.
- **Backpressure:**
  - Requester 2 is granted with resp_rdy[2]=0 for 3 cycles.
  - Required during those cycles: req_rdy=0, resp_msg held, rand unchanged.
  - Required on the resp_rdy[2] cycle: the next grant is issued in that same cycle.
  - Required: resp_rdy[1]=1 has no effect on the pending response.
- **Zero seed:** cfg_seed_val=1 with cfg_seed=0 while req_val=1. Required: no grant that cycle; the next response is 0xfc.
- **Reseed with drain:** cfg_seed=0xdeadbeef in the same cycle a pending response drains. Required: drain completes, resp_val=0 the next cycle, and the next fire yields 0xfc.
- **Async reset while FULL:** assert reset_n=0 mid-cycle. Required: resp_val=0 immediately; after release, ptr=0 and the first response is 0xfc.
